// File: rtl/lab2_proc_fetch_buffer_pkg.sv
// Shared definitions for the fetch buffer: default sizes and width helpers.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package lab2_proc_fetch_buffer_pkg;

  localparam int unsigned DFLT_NUM_ENTRIES  = 2;
  localparam int unsigned DFLT_MAX_INFLIGHT = 4;
  localparam int unsigned DFLT_DATA_NBITS   = 32;

  // Bits needed to hold a counter that ranges 0..max_val inclusive.
  function automatic int unsigned cnt_nbits(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Bits needed to index num_entries slots (at least one bit).
  function automatic int unsigned ptr_nbits(input int unsigned num_entries);
    return (num_entries <= 1) ? 1 : $clog2(num_entries);
  endfunction

endpackage

// File: rtl/lab2_proc_fetch_buffer_if.sv
// Bundle of the fetch, imem request/response, squash and D-stage handshakes.
// Latency: wires only.
// Backpressure: each val has a matching rdy; squash has none.
interface lab2_proc_fetch_buffer_if
  import lab2_proc_fetch_buffer_pkg::*;
#(
  parameter int unsigned p_data_nbits = DFLT_DATA_NBITS
);

  logic                    fetch_val;
  logic                    fetch_rdy;
  logic                    imemreq_val;
  logic                    imemreq_rdy;
  logic                    imemresp_val;
  logic                    imemresp_rdy;
  logic [p_data_nbits-1:0] imemresp_data;
  logic                    squash;
  logic                    inst_val;
  logic                    inst_rdy;
  logic [p_data_nbits-1:0] inst_data;

  // Buffer side.
  modport master (
    input  fetch_val, imemreq_rdy, imemresp_val, imemresp_data, squash, inst_rdy,
    output fetch_rdy, imemreq_val, imemresp_rdy, inst_val, inst_data
  );

  // Surrounding pipeline / memory side.
  modport slave (
    output fetch_val, imemreq_rdy, imemresp_val, imemresp_data, squash, inst_rdy,
    input  fetch_rdy, imemreq_val, imemresp_rdy, inst_val, inst_data
  );

endinterface

// File: rtl/lab2_proc_fetch_buffer_queue.sv
// Circular in-order response queue with enqueue, dequeue and flush.
// Latency: an enqueued word is visible at the head the cycle after its enqueue edge.
// Backpressure: caller gates enq on space (enq+deq when full is legal); flush beats enq.
module lab2_proc_fetch_buffer_queue
  import lab2_proc_fetch_buffer_pkg::*;
#(
  parameter int unsigned p_num_entries = DFLT_NUM_ENTRIES,
  parameter int unsigned p_data_nbits  = DFLT_DATA_NBITS
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  enq_val,
  input  logic [p_data_nbits-1:0]               enq_data,
  input  logic                                  deq_val,
  input  logic                                  flush,
  output logic [cnt_nbits(p_num_entries)-1:0]   count,
  output logic [p_data_nbits-1:0]               deq_data
);

  localparam int unsigned PW = ptr_nbits(p_num_entries);
  localparam int unsigned CW = cnt_nbits(p_num_entries);

  logic [p_data_nbits-1:0] mem [p_num_entries];
  logic [PW-1:0]           rd_ptr;
  logic [PW-1:0]           wr_ptr;

  // Pointers wrap at the entry count, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(p_num_entries - 1)) ? '0 : p + PW'(1);
  endfunction

  assign deq_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; a flush realigns the read pointer onto the write pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (enq_val) wr_ptr <= ptr_inc(wr_ptr);
      if (deq_val) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(enq_val) - CW'(deq_val);
    end
  end

  // Storage needs no reset: nothing reads a slot before it has been written.
  always_ff @(posedge clk) begin
    if (enq_val && !flush) mem[wr_ptr] <= enq_data;
  end

endmodule

// File: rtl/lab2_proc_fetch_buffer.sv
// Fetch buffer: issues imem requests under an in-flight budget, queues responses, drops squashed ones.
// Latency: a response accepted on one edge is presented to D on the next cycle; no bypass.
// Backpressure: fetch_rdy throttles on imem ready, in-flight budget and live-slot budget; squash kills D output.
module lab2_proc_fetch_buffer
  import lab2_proc_fetch_buffer_pkg::*;
#(
  parameter int unsigned p_num_entries  = DFLT_NUM_ENTRIES,
  parameter int unsigned p_max_inflight = DFLT_MAX_INFLIGHT,
  parameter int unsigned p_data_nbits   = DFLT_DATA_NBITS
) (
  input  logic                     clk,
  input  logic                     reset,
  lab2_proc_fetch_buffer_if.master bus
);

  localparam int unsigned IW = cnt_nbits(p_max_inflight);
  localparam int unsigned QW = cnt_nbits(p_num_entries);
  localparam int unsigned LW = cnt_nbits(p_max_inflight + p_num_entries);

  logic [IW-1:0]           inflight;
  logic [IW-1:0]           drop_cnt;
  logic [QW-1:0]           count;
  logic [LW-1:0]           live;
  logic [p_data_nbits-1:0] head_data;
  logic                    fetch_rdy;
  logic                    req_fire;
  logic                    resp_rdy;
  logic                    resp_fire;
  logic                    inst_val;
  logic                    deq;
  logic                    enq;

  // Live fetches are those whose instruction will still reach D: undropped in-flight plus queued.
  assign live      = LW'(inflight) - LW'(drop_cnt) + LW'(count);
  assign fetch_rdy = reset & bus.imemreq_rdy
                   & (inflight < IW'(p_max_inflight))
                   & (live < LW'(p_num_entries));
  assign req_fire  = bus.fetch_val & fetch_rdy;

  // Responses due for dropping, or arriving during a squash, never need queue space.
  assign resp_rdy  = (drop_cnt != '0) | bus.squash | (count < QW'(p_num_entries));
  assign resp_fire = bus.imemresp_val & resp_rdy;
  assign enq       = resp_fire & (drop_cnt == '0) & ~bus.squash;

  assign inst_val  = (count != '0) & ~bus.squash;
  assign deq       = inst_val & bus.inst_rdy;

  assign bus.fetch_rdy    = fetch_rdy;
  assign bus.imemreq_val  = req_fire;
  assign bus.imemresp_rdy = resp_rdy;
  assign bus.inst_val     = inst_val;
  assign bus.inst_data    = head_data;

  lab2_proc_fetch_buffer_queue #(
    .p_num_entries (p_num_entries),
    .p_data_nbits  (p_data_nbits)
  ) queue (
    .clk      (clk),
    .reset    (reset),
    .enq_val  (enq),
    .enq_data (bus.imemresp_data),
    .deq_val  (deq),
    .flush    (bus.squash),
    .count    (count),
    .deq_data (head_data)
  );

  // Track outstanding requests and how many of the oldest ones belong to squashed fetches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight + IW'(req_fire) - IW'(resp_fire);
      if (bus.squash) begin
        // Everything older than this cycle is dead; a request issued now is not.
        drop_cnt <= inflight - IW'(resp_fire);
      end else if (resp_fire && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - IW'(1);
      end
    end
  end

  // A response with nothing outstanding is a memory-side protocol error.
  always_ff @(posedge clk) begin
    if (reset && resp_fire) assert (inflight != '0);
  end

endmodule
